// File: rtl/xdat_sram_arb.sv
// Arbiter sharing the single xdata SRAM port between the 8051 CPU (fixed priority) and an AUX
// master with bounded wait. Define XDAT_ARB_PROT_EN to add the AUX write-protect window.
module xdat_sram_arb #(
  parameter int unsigned AW      = 11,
  parameter int unsigned DEPTH   = 1536,
  parameter int unsigned MAXWAIT = 4
) (
  input  logic          i_clk,
  input  logic          i_rstz,
  input  logic          i_sleep,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdat,
  output logic          cpu_stall,
  output logic [7:0]    cpu_rdat,
  output logic          cpu_rvld,
  input  logic          aux_req,
  input  logic          aux_we,
  input  logic [AW-1:0] aux_addr,
  input  logic [7:0]    aux_wdat,
  output logic          aux_ack,
  output logic [7:0]    aux_rdat,
  output logic          aux_rvld,
`ifdef XDAT_ARB_PROT_EN
  input  logic [AW-1:0] prot_lo,
  input  logic [AW-1:0] prot_hi,
  output logic          err_prot,
`endif
  output logic          err_oor,
  input  logic          err_clr,
  output logic          sram_ceb,
  output logic          sram_web,
  output logic          sram_oeb,
  output logic [AW-1:0] sram_a,
  output logic [7:0]    sram_d,
  input  logic [7:0]    sram_rdat
);

  localparam logic [3:0] MaxWait = 4'(MAXWAIT);
  localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);

  logic          grant_cpu, grant_aux, grant_any;
  logic          sel_we, sel_oor, prot_blk, issue;
  logic [AW-1:0] sel_addr;
  logic [7:0]    sel_wdat;

  logic [3:0]    wcnt_d, wcnt_q;
  logic          ceb_d, ceb_q, web_d, web_q, oeb_d, oeb_q;
  logic [AW-1:0] a_d, a_q;
  logic [7:0]    d_d, d_q;
  logic          rd_cpu_d, rd_cpu_q, rd_aux_d, rd_aux_q, rd_oor_d, rd_oor_q;
  logic          cpu_rvld_d, cpu_rvld_q, aux_rvld_d, aux_rvld_q;
  logic [7:0]    cpu_rdat_d, cpu_rdat_q, aux_rdat_d, aux_rdat_q;
  logic          err_oor_d, err_oor_q;
  logic          err_prot_d, err_prot_q;

  // Grants are held off during reset so nothing is accepted that the reset would then lose.
  always_comb begin
    grant_cpu = 1'b0;
    grant_aux = 1'b0;
    if (i_rstz && !i_sleep) begin
      if (aux_req && (wcnt_q == MaxWait)) begin
        grant_aux = 1'b1;
      end else if (cpu_req) begin
        grant_cpu = 1'b1;
      end else if (aux_req) begin
        grant_aux = 1'b1;
      end
    end
  end

  assign grant_any = grant_cpu | grant_aux;
  assign cpu_stall = cpu_req & ~grant_cpu;
  assign aux_ack   = grant_aux;

  always_comb begin
    sel_we   = grant_aux ? aux_we   : cpu_we;
    sel_addr = grant_aux ? aux_addr : cpu_addr;
    sel_wdat = grant_aux ? aux_wdat : cpu_wdat;
    sel_oor  = grant_any & ({1'b0, sel_addr} >= DepthW);
`ifdef XDAT_ARB_PROT_EN
    prot_blk = grant_aux & aux_we & ((aux_addr < prot_lo) | (aux_addr > prot_hi));
`else
    prot_blk = 1'b0;
`endif
    issue    = grant_any & ~sel_oor & ~prot_blk;
  end

  // Starvation counter: frozen while asleep, cleared once AUX is served or withdraws.
  always_comb begin
    wcnt_d = wcnt_q;
    if (!i_sleep) begin
      if (!aux_req || grant_aux) begin
        wcnt_d = 4'd0;
      end else if (wcnt_q != MaxWait) begin
        wcnt_d = wcnt_q + 4'd1;
      end
    end
  end

  // Issue stage: address/data hold their last values when nothing is issued.
  always_comb begin
    ceb_d = ~issue;
    web_d = ~(issue & sel_we);
    oeb_d = ~(issue & ~sel_we);
    a_d   = issue ? sel_addr : a_q;
    d_d   = (issue & sel_we) ? sel_wdat : d_q;
  end

  // Read tracking: out-of-range reads still return, with all-ones data.
  always_comb begin
    rd_cpu_d   = grant_cpu & ~cpu_we;
    rd_aux_d   = grant_aux & ~aux_we;
    rd_oor_d   = sel_oor;
    cpu_rvld_d = rd_cpu_q;
    aux_rvld_d = rd_aux_q;
    cpu_rdat_d = cpu_rdat_q;
    aux_rdat_d = aux_rdat_q;
    if (rd_cpu_q) begin
      cpu_rdat_d = rd_oor_q ? 8'hFF : sram_rdat;
    end
    if (rd_aux_q) begin
      aux_rdat_d = rd_oor_q ? 8'hFF : sram_rdat;
    end
  end

  // Set wins over clear.
  always_comb begin
    err_oor_d  = sel_oor | (err_oor_q & ~err_clr);
    err_prot_d = prot_blk | (err_prot_q & ~err_clr);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstz) begin
      wcnt_q     <= 4'd0;
      ceb_q      <= 1'b1;
      web_q      <= 1'b1;
      oeb_q      <= 1'b1;
      a_q        <= '0;
      d_q        <= 8'h00;
      rd_cpu_q   <= 1'b0;
      rd_aux_q   <= 1'b0;
      rd_oor_q   <= 1'b0;
      cpu_rvld_q <= 1'b0;
      aux_rvld_q <= 1'b0;
      cpu_rdat_q <= 8'h00;
      aux_rdat_q <= 8'h00;
      err_oor_q  <= 1'b0;
      err_prot_q <= 1'b0;
    end else begin
      wcnt_q     <= wcnt_d;
      ceb_q      <= ceb_d;
      web_q      <= web_d;
      oeb_q      <= oeb_d;
      a_q        <= a_d;
      d_q        <= d_d;
      rd_cpu_q   <= rd_cpu_d;
      rd_aux_q   <= rd_aux_d;
      rd_oor_q   <= rd_oor_d;
      cpu_rvld_q <= cpu_rvld_d;
      aux_rvld_q <= aux_rvld_d;
      cpu_rdat_q <= cpu_rdat_d;
      aux_rdat_q <= aux_rdat_d;
      err_oor_q  <= err_oor_d;
      err_prot_q <= err_prot_d;
    end
  end

  assign sram_ceb = ceb_q;
  assign sram_web = web_q;
  assign sram_oeb = oeb_q;
  assign sram_a   = a_q;
  assign sram_d   = d_q;
  assign cpu_rvld = cpu_rvld_q;
  assign aux_rvld = aux_rvld_q;
  assign cpu_rdat = cpu_rdat_q;
  assign aux_rdat = aux_rdat_q;
  assign err_oor  = err_oor_q;
`ifdef XDAT_ARB_PROT_EN
  assign err_prot = err_prot_q;
`endif

endmodule

// File: tb/tb_xdat_sram_arb.sv
// Randomized bench for xdat_sram_arb: a per-cycle transaction model predicts grants, SRAM
// pins, read returns and error flags; a behavioural SRAM sits on the macro port.
module tb_xdat_sram_arb;
  localparam int unsigned AW      = 11;
  localparam int unsigned DEPTH   = 1536;
  localparam int unsigned MAXWAIT = 4;

  logic          clk = 1'b0;
  logic          i_rstz, i_sleep;
  logic          cpu_req, cpu_we, cpu_stall, cpu_rvld;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdat, cpu_rdat;
  logic          aux_req, aux_we, aux_ack, aux_rvld;
  logic [AW-1:0] aux_addr;
  logic [7:0]    aux_wdat, aux_rdat;
  logic          err_oor, err_clr;
  logic          sram_ceb, sram_web, sram_oeb;
  logic [AW-1:0] sram_a;
  logic [7:0]    sram_d, sram_rdat;
`ifdef XDAT_ARB_PROT_EN
  logic [AW-1:0] prot_lo = 11'h100;
  logic [AW-1:0] prot_hi = 11'h1FF;
  logic          err_prot;
`endif

  always #5 clk = ~clk;

  xdat_sram_arb #(.AW(AW), .DEPTH(DEPTH), .MAXWAIT(MAXWAIT)) dut (
    .i_clk(clk), .i_rstz(i_rstz), .i_sleep(i_sleep),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdat(cpu_wdat),
    .cpu_stall(cpu_stall), .cpu_rdat(cpu_rdat), .cpu_rvld(cpu_rvld),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdat(aux_wdat),
    .aux_ack(aux_ack), .aux_rdat(aux_rdat), .aux_rvld(aux_rvld),
`ifdef XDAT_ARB_PROT_EN
    .prot_lo(prot_lo), .prot_hi(prot_hi), .err_prot(err_prot),
`endif
    .err_oor(err_oor), .err_clr(err_clr),
    .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_oeb(sram_oeb),
    .sram_a(sram_a), .sram_d(sram_d), .sram_rdat(sram_rdat)
  );

  // Behavioural SRAM macro: write at the clock edge, read data valid during the access cycle.
  logic [7:0] mem [DEPTH];
  logic       mem_init = 1'b1;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'(i * 37 + 11);
    end else if (!sram_ceb && !sram_web && int'(sram_a) < DEPTH) begin
      mem[sram_a] <= sram_d;
    end
  end
  assign sram_rdat = (!sram_ceb && !sram_oeb && int'(sram_a) < DEPTH) ? mem[sram_a] : 8'hA5;

  // Reference model state.
  typedef struct {bit vld; bit aux; logic [7:0] data;} ret_t;
  logic [7:0]    ref_mem [DEPTH];
  int            m_wcnt;
  bit            m_err_oor, m_err_prot;
  bit            e_ceb, e_web, e_oeb;
  logic [AW-1:0] e_a;
  logic [7:0]    e_d, m_cpu_rdat, m_aux_rdat;
  ret_t          r1, r2;
  bit            last_g_cpu, last_g_aux;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wcnt = 0; m_err_oor = 0; m_err_prot = 0;
    e_ceb = 1; e_web = 1; e_oeb = 1; e_a = '0; e_d = 8'h00;
    m_cpu_rdat = 8'h00; m_aux_rdat = 8'h00;
    r1 = '{vld: 1'b0, aux: 1'b0, data: 8'h00};
    r2 = r1;
  endtask

  // One clock cycle: check everything at the falling edge, advance the model, step past the
  // rising edge.
  task automatic tick();
    bit            g_cpu, g_aux, we, oor, blk, issue;
    logic [AW-1:0] addr;
    logic [7:0]    wd;
    @(negedge clk);
    check_eq("sram_ceb", sram_ceb, e_ceb);
    check_eq("sram_web", sram_web, e_web);
    check_eq("sram_oeb", sram_oeb, e_oeb);
    check_eq("sram_a", sram_a, e_a);
    check_eq("sram_d", sram_d, e_d);
    if (r2.vld && !r2.aux) m_cpu_rdat = r2.data;
    if (r2.vld && r2.aux) m_aux_rdat = r2.data;
    check_eq("cpu_rvld", cpu_rvld, r2.vld && !r2.aux);
    check_eq("aux_rvld", aux_rvld, r2.vld && r2.aux);
    check_eq("cpu_rdat", cpu_rdat, m_cpu_rdat);
    check_eq("aux_rdat", aux_rdat, m_aux_rdat);
    check_eq("err_oor", err_oor, m_err_oor);
`ifdef XDAT_ARB_PROT_EN
    check_eq("err_prot", err_prot, m_err_prot);
`endif
    g_cpu = 0;
    g_aux = 0;
    if (i_rstz && !i_sleep) begin
      if (aux_req && m_wcnt == MAXWAIT) g_aux = 1;
      else if (cpu_req) g_cpu = 1;
      else if (aux_req) g_aux = 1;
    end
    if (i_rstz) begin
      check_eq("cpu_stall", cpu_stall, cpu_req && !g_cpu);
      check_eq("aux_ack", aux_ack, g_aux);
    end
    we   = g_aux ? aux_we : cpu_we;
    addr = g_aux ? aux_addr : cpu_addr;
    wd   = g_aux ? aux_wdat : cpu_wdat;
    oor  = (g_cpu || g_aux) && int'(addr) >= DEPTH;
    blk  = 0;
`ifdef XDAT_ARB_PROT_EN
    blk  = g_aux && aux_we && (aux_addr < prot_lo || aux_addr > prot_hi);
`endif
    issue = (g_cpu || g_aux) && !oor && !blk;
    r2 = r1;
    r1.vld  = (g_cpu || g_aux) && !we;
    r1.aux  = g_aux;
    r1.data = oor ? 8'hFF : ref_mem[oor ? 0 : int'(addr)];
    if (issue && we) ref_mem[addr] = wd;
    e_ceb = !issue;
    e_web = !(issue && we);
    e_oeb = !(issue && !we);
    if (issue) e_a = addr;
    if (issue && we) e_d = wd;
    m_err_oor  = oor || (m_err_oor && !err_clr);
    m_err_prot = blk || (m_err_prot && !err_clr);
    if (!i_sleep) begin
      if (aux_req && !g_aux) m_wcnt = (m_wcnt < MAXWAIT) ? m_wcnt + 1 : MAXWAIT;
      else m_wcnt = 0;
    end
    if (!i_rstz) model_reset();
    last_g_cpu = g_cpu;
    last_g_aux = g_aux;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int unsigned r = $urandom_range(0, 9);
    if (r < 5) return AW'($urandom_range(0, 15));
    if (r < 7) return AW'($urandom_range(32'h1FC, 32'h203));
    if (r < 9) return AW'($urandom_range(DEPTH - 4, DEPTH + 3));
    return AW'($urandom);
  endfunction

  task automatic set_cpu(input bit req, input bit we, input int addr, input int wd);
    cpu_req = req; cpu_we = we; cpu_addr = AW'(addr); cpu_wdat = 8'(wd);
  endtask

  task automatic set_aux(input bit req, input bit we, input int addr, input int wd);
    aux_req = req; aux_we = we; aux_addr = AW'(addr); aux_wdat = 8'(wd);
  endtask

  // New requests only once the previous one was accepted.
  task automatic drive_rand();
    if (!cpu_req || last_g_cpu)
      set_cpu($urandom_range(0, 99) < 60, $urandom_range(0, 1), int'(rand_addr()), $urandom);
    if (!aux_req || last_g_aux)
      set_aux($urandom_range(0, 99) < 50, $urandom_range(0, 1), int'(rand_addr()), $urandom);
    i_sleep = $urandom_range(0, 99) < 8;
    err_clr = $urandom_range(0, 99) < 5;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'(i * 37 + 11);
    model_reset();
    last_g_cpu = 0;
    last_g_aux = 0;
    i_rstz = 0; i_sleep = 0; err_clr = 0;
    set_cpu(1, 0, 'h010, 0);
    set_aux(0, 0, 0, 0);
    @(posedge clk);
    #1;
    mem_init = 0;
    // Reset held with a pending CPU request.
    tick();
    tick();
    i_rstz = 1;
    tick();
    // CPU write then read of the same location.
    set_cpu(1, 1, 'h123, 'h5A); tick();
    set_cpu(1, 0, 'h123, 0);    tick();
    set_cpu(0, 0, 0, 0);        tick(); tick();
    // Starvation: both masters requesting every cycle.
    set_cpu(1, 1, 'h004, 'h11);
    set_aux(1, 0, 'h005, 0);
    for (int i = 0; i < 15; i++) begin
      if (last_g_cpu) set_cpu(1, i[0], i, i + 'h40);
      if (last_g_aux) set_aux(1, 0, i + 2, 0);
      tick();
    end
    set_cpu(0, 0, 0, 0); set_aux(0, 0, 0, 0); tick(); tick();
    // Out-of-range CPU read, flag sticky until cleared.
    set_cpu(1, 0, 'h600, 0); tick();
    set_cpu(1, 1, 'h5FF, 'hC3); tick();
    set_cpu(0, 0, 0, 0); tick(); tick(); tick();
    err_clr = 1; tick();
    err_clr = 0; tick();
    // Sleep with a waiting AUX, then release.
    i_sleep = 1;
    set_aux(1, 1, 'h007, 'h99);
    tick(); tick(); tick();
    i_sleep = 0; tick();
    set_aux(0, 0, 0, 0);
    // Sleep with the counter part-way: it must resume, not restart.
    set_cpu(1, 0, 'h001, 0); set_aux(1, 0, 'h002, 0); tick(); tick();
    i_sleep = 1; tick(); tick(); tick();
    i_sleep = 0;
    for (int i = 0; i < 4; i++) begin
      if (last_g_aux) set_aux(0, 0, 0, 0);
      tick();
    end
    set_cpu(0, 0, 0, 0); set_aux(0, 0, 0, 0); tick(); tick();
`ifdef XDAT_ARB_PROT_EN
    set_aux(1, 1, 'h080, 'h77); tick();
    set_aux(1, 1, 'h150, 'h78); tick();
    set_aux(1, 0, 'h150, 0);    tick();
    set_aux(0, 0, 0, 0);        tick(); tick();
`endif
    // Randomized traffic with one reset landing on an in-flight read.
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        set_cpu(1, 0, 'h003, 0); set_aux(0, 0, 0, 0); i_sleep = 0; err_clr = 0;
        tick();
        i_rstz = 0; tick();
        i_rstz = 1;
      end
      drive_rand();
      tick();
    end
    set_cpu(0, 0, 0, 0); set_aux(0, 0, 0, 0); i_sleep = 0; err_clr = 0;
    tick(); tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/xdat_sram_arb.md
Name: xdat_sram_arb

Overview:
- Two-port arbiter for the 1536x8 xdata SRAM macro.
- Shares the single SRAM port between the 8051 core xdata bus (CPU) and an auxiliary master (AUX: the CC-I2C/I2C slave bridge).
- Sits between core_a0 and the SRAM wrapper, on the existing SRAM_CEB/WEB/OEB/A/D/RDAT path.
- CPU has fixed priority; a starvation counter bounds AUX latency. It also enforces the SRAM address range and a sleep gate.

Parameters:
- AW, 11, address width.
- DEPTH, 1536, valid SRAM locations; addresses >= DEPTH are out of range.
- MAXWAIT, 4, consecutive cycles AUX may be refused before it takes priority (1..15).

Ports:
- i_clk  in  1  system clock (mclk).
- i_rstz  in  1  reset, synchronous, active-low.
- i_sleep  in  1  1 = no new SRAM access is issued.
- cpu_req  in  1  CPU access request, held until not stalled.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  CPU address.
- cpu_wdat  in  8  CPU write data.
- cpu_stall  out  1  combinational; 1 = CPU request not accepted this cycle.
- cpu_rdat  out  8  CPU read data.
- cpu_rvld  out  1  CPU read data valid pulse.
- aux_req  in  1  AUX request, held until aux_ack.
- aux_we  in  1  AUX write.
- aux_addr  in  AW  AUX address.
- aux_wdat  in  8  AUX write data.
- aux_ack  out  1  combinational one-cycle accept pulse.
- aux_rdat  out  8  AUX read data.
- aux_rvld  out  1  AUX read data valid pulse.
- err_oor  out  1  sticky out-of-range flag.
- err_clr  in  1  clears err_oor.
- sram_ceb  out  1  SRAM chip enable, low-active.
- sram_web  out  1  SRAM write enable, low-active.
- sram_oeb  out  1  SRAM output enable, low-active.
- sram_a  out  AW  SRAM address.
- sram_d  out  8  SRAM write data.
- sram_rdat  in  8  SRAM read data.

Behaviour:
- Reset (i_rstz=0 at edge) values:
  - sram_ceb=1, sram_web=1, sram_oeb=1, sram_a=0, sram_d=0.
  - cpu_rvld=0, aux_rvld=0, cpu_rdat=8'h00, aux_rdat=8'h00.
  - err_oor=0, wait counter=0, in-flight pipeline cleared.
- Reset mid-read: no rvld pulse is produced for that read.
- Grant decision is combinational in cycle N:
  - If i_sleep=1: no grant; cpu_stall=cpu_req, aux_ack=0.
  - Else if aux_req and wcnt==MAXWAIT: grant AUX.
  - Else if cpu_req: grant CPU.
  - Else if aux_req: grant AUX.
  - cpu_stall = cpu_req & ~grant_cpu. aux_ack = grant_aux.
- Wait counter wcnt (4-bit):
  - Increments when aux_req=1 and no AUX grant, saturating at MAXWAIT.
  - Cleared on AUX grant or when aux_req=0.
  - Consequence: AUX is refused at most MAXWAIT cycles; CPU then stalls exactly one cycle.
- Issue (registered, cycle N+1), for a granted in-range access:
  - sram_ceb=0, sram_a=addr.
  - Write: sram_web=0, sram_oeb=1, sram_d=wdat.
  - Read: sram_web=1, sram_oeb=0.
  - No grant: sram_ceb=sram_web=sram_oeb=1; sram_a/sram_d hold their last values.
- Read return:
  - The requester's rvld pulses one cycle in cycle N+2.
  - rdat is registered, captured from sram_rdat at the end of cycle N+1 (macro data valid after the N+1 edge).
  - rdat holds until the next read return for that port.
  - Back-to-back grants allowed every cycle; reads and writes may interleave with no turnaround.
- Out of range (addr >= DEPTH):
  - The grant and ack/stall still occur, but sram_ceb stays 1 in N+1.
  - err_oor is set in N+1.
  - A read still returns in N+2 with rdat=8'hFF.
  - Writes are dropped.
- err_oor: set has priority over err_clr in the same cycle.
- Simultaneous cpu_req and aux_req with wcnt<MAXWAIT: CPU wins, wcnt increments.

Optional Feature:
- Macro XDAT_ARB_PROT_EN.
- When defined:
  - Adds inputs prot_lo[AW-1:0] and prot_hi[AW-1:0], plus output err_prot (sticky, also cleared by err_clr).
  - An AUX write with address outside [prot_lo, prot_hi] is acked but not issued (sram_ceb=1), and sets err_prot.
  - AUX reads and all CPU accesses are unaffected.
- When undefined: ports absent and all in-range AUX writes are issued.

Test Plan:
- Reset: hold i_rstz=0 for 2 cycles with cpu_req=1 -> sram_ceb=1, all rvld=0, err_oor=0; first issue occurs no earlier than 1 cycle after release.
- CPU write then read: write 8'h5A to addr 0x123, then read 0x123 -> sram_web=0 in N+1, cpu_rvld in cycle N+2 of the read with cpu_rdat=8'h5A, cpu_stall=0 throughout.
- Starvation (MAXWAIT=4): cpu_req and aux_req held continuously -> CPU granted 4 cycles, AUX acked in cycle 5 with cpu_stall=1 that cycle; the pattern then repeats.
- Out of range: CPU read at 0x600 -> sram_ceb stays 1, cpu_rvld with cpu_rdat=8'hFF, err_oor=1 until err_clr pulse.
- Sleep: i_sleep=1 with aux_req=1 -> no aux_ack, sram_ceb=1, wcnt unchanged; deassert -> AUX acked next cycle.
- XDAT_ARB_PROT_EN: prot window 0x100-0x1FF, AUX write to 0x080 -> aux_ack, no SRAM write, err_prot=1; AUX write to 0x150 is issued.
